// File: rtl/calc_ctrl.sv
// -----------------------------------------------------------------------------
// calc_ctrl
//
// Control and arithmetic core for a small keypad calculator. It collects an
// operand A, an operator and an operand B from a keyboard front end, then
// computes A+B, A-B (as sign + magnitude) or A*B. Add and subtract take a
// single cycle. Multiply uses an 8-step shift-add over B, starting at the LSB.
//
// Ports
//   clk             in   1   system clock, rising edge
//   rst             in   1   synchronous active-high reset
//   valid           in   1   strobe: num_or_operand carries a new value
//   num_or_operand  in   8   number (op_ctrl=0) or operator code in [3:0]
//   enter_edge      in   1   strobe: Enter key pressed
//   op_ctrl         out  1   1 = keyboard should deliver operators
//   busy            out  1   calculation in progress
//   result          out 16   magnitude of the last result
//   result_neg      out  1   sign of the last result (1 = negative)
//   result_valid    out  1   strobe: result/result_neg just updated
//   state_dbg       out  3   current state code
// -----------------------------------------------------------------------------
module calc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [7:0]  num_or_operand,
  input  logic        enter_edge,
  output logic        op_ctrl,
  output logic        busy,
  output logic [15:0] result,
  output logic        result_neg,
  output logic        result_valid,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_CALC = 3'd3,
    S_DONE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_e;

  localparam logic [3:0] CODE_ADD = 4'hA;
  localparam logic [3:0] CODE_SUB = 4'hB;
  localparam logic [3:0] CODE_MUL = 4'hC;
  localparam logic [3:0] CODE_CLR = 4'hD;

  localparam logic [2:0] MUL_LAST = 3'd7;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  op_e         op_q, op_d;
  logic        a_seen_q, a_seen_d;
  logic        b_seen_q, b_seen_d;
  logic [15:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] result_q, result_d;
  logic        neg_q, neg_d;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  logic [3:0]  code;
  logic [8:0]  sum_ab;
  logic [7:0]  diff_ab;
  logic [7:0]  diff_ba;
  logic        a_ge_b;
  logic [15:0] partial;

  assign code    = num_or_operand[3:0];
  assign sum_ab  = {1'b0, a_q} + {1'b0, b_q};
  assign diff_ab = a_q - b_q;
  assign diff_ba = b_q - a_q;
  assign a_ge_b  = (a_q >= b_q);

  // The multiplier bit is selected by the step counter, so the operand
  // registers stay stable for the whole multiply and no shifting copies of
  // A or B are needed.
  assign partial = b_q[cnt_q] ? ({8'd0, a_q} << cnt_q) : 16'd0;

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so that no path
    // through the case statement leaves one unassigned and infers a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    a_seen_d = a_seen_q;
    b_seen_d = b_seen_q;
    result_d = result_q;
    neg_d    = neg_q;
    // The accumulator and step counter only carry meaning inside S_CALC.
    // Everywhere else they sit at zero, ready for the next multiply.
    acc_d    = 16'd0;
    cnt_d    = 3'd0;

    unique case (state_q)
      S_A: begin
        if (valid) begin
          a_d      = num_or_operand;
          a_seen_d = 1'b1;
        end
        // A value arriving together with Enter counts as seen, so the
        // freshly captured number is the one that gets committed.
        if (enter_edge && (a_seen_q || valid)) begin
          state_d = S_OP;
        end
      end

      S_OP: begin
        if (valid) begin
          unique case (code)
            CODE_ADD: begin op_d = OP_ADD; state_d = S_B; end
            CODE_SUB: begin op_d = OP_SUB; state_d = S_B; end
            CODE_MUL: begin op_d = OP_MUL; state_d = S_B; end
            CODE_CLR: begin
              a_d      = 8'd0;
              a_seen_d = 1'b0;
              state_d  = S_A;
            end
            default: ;  // unknown operator codes are ignored
          endcase
        end
      end

      S_B: begin
        if (valid) begin
          b_d      = num_or_operand;
          b_seen_d = 1'b1;
        end
        if (enter_edge && (b_seen_q || valid)) begin
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        unique case (op_q)
          OP_ADD: begin
            result_d = {7'd0, sum_ab};
            neg_d    = 1'b0;
            state_d  = S_DONE;
          end
          OP_SUB: begin
            result_d = a_ge_b ? {8'd0, diff_ab} : {8'd0, diff_ba};
            neg_d    = ~a_ge_b;
            state_d  = S_DONE;
          end
          OP_MUL: begin
            acc_d = acc_q + partial;
            cnt_d = cnt_q + 3'd1;
            // Only the last step publishes the product; intermediate
            // partial sums stay inside the accumulator.
            if (cnt_q == MUL_LAST) begin
              result_d = acc_q + partial;
              neg_d    = 1'b0;
              state_d  = S_DONE;
            end
          end
          default: state_d = S_DONE;
        endcase
      end

      S_DONE: begin
        a_seen_d = 1'b0;
        b_seen_d = 1'b0;
        state_d  = S_A;
      end

      default: state_d = S_A;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register, regardless of the
  // order of the statements below.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_A;
      a_q      <= 8'd0;
      b_q      <= 8'd0;
      op_q     <= OP_ADD;
      a_seen_q <= 1'b0;
      b_seen_q <= 1'b0;
      acc_q    <= 16'd0;
      cnt_q    <= 3'd0;
      result_q <= 16'd0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      a_seen_q <= a_seen_d;
      b_seen_q <= b_seen_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      neg_q    <= neg_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: pure decodes of registered state, so they are glitch-free and
  // all take their idle values in the cycle after reset.
  // ---------------------------------------------------------------------------
  assign op_ctrl      = (state_q == S_OP);
  assign busy         = (state_q == S_CALC);
  assign result_valid = (state_q == S_DONE);
  assign state_dbg    = state_q;
  assign result       = result_q;
  assign result_neg   = neg_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_calc_ctrl
//
// Directed test of calc_ctrl. Inputs change 1 time unit after a rising edge
// and outputs are sampled at that same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_calc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [7:0]  num_or_operand;
  logic        enter_edge;
  logic        op_ctrl;
  logic        busy;
  logic [15:0] result;
  logic        result_neg;
  logic        result_valid;
  logic [2:0]  state_dbg;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  calc_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .valid          (valid),
    .num_or_operand (num_or_operand),
    .enter_edge     (enter_edge),
    .op_ctrl        (op_ctrl),
    .busy           (busy),
    .result         (result),
    .result_neg     (result_neg),
    .result_valid   (result_valid),
    .state_dbg      (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    valid          = 1'b1;
    num_or_operand = v;
    step();
    valid          = 1'b0;
    num_or_operand = 8'd0;
  endtask

  task automatic enter();
    enter_edge = 1'b1;
    step();
    enter_edge = 1'b0;
  endtask

  // Full A / op / B / Enter sequence with expected result and the number of
  // cycles busy must stay high. With noise set, valid+enter (and a clear
  // code) are driven during the whole calculation and must change nothing.
  task automatic run_calc(input string tag, input logic [7:0] a, input logic [3:0] op,
                          input logic [7:0] b, input int unsigned exp_res,
                          input bit exp_neg, input int unsigned exp_cycles,
                          input bit noise);
    int unsigned prev;
    int unsigned n;
    send(a);
    check({tag, " state after A"}, 32'(state_dbg), 0);
    enter();
    check({tag, " op_ctrl in S_OP"}, 32'(op_ctrl), 1);
    send({4'h5, op});  // upper nibble must be ignored
    check({tag, " op_ctrl in S_B"}, 32'(op_ctrl), 0);
    check({tag, " state S_B"}, 32'(state_dbg), 2);
    send(b);
    prev = 32'(result);
    enter_edge = 1'b1;
    step();
    enter_edge = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      check({tag, " result held while busy"}, 32'(result), prev);
      check({tag, " no result_valid while busy"}, 32'(result_valid), 0);
      n++;
      if (noise) begin
        valid          = 1'b1;
        num_or_operand = 8'h0D;
        enter_edge     = 1'b1;
      end
      step();
      valid          = 1'b0;
      num_or_operand = 8'd0;
      enter_edge     = 1'b0;
    end
    check({tag, " busy cycles"}, n, exp_cycles);
    check({tag, " result_valid"}, 32'(result_valid), 1);
    check({tag, " result"}, 32'(result), exp_res);
    check({tag, " result_neg"}, 32'(result_neg), 32'(exp_neg));
    check({tag, " state S_DONE"}, 32'(state_dbg), 4);
    step();
    check({tag, " result_valid one cycle"}, 32'(result_valid), 0);
    check({tag, " back to S_A"}, 32'(state_dbg), 0);
    check({tag, " result holds"}, 32'(result), exp_res);
  endtask

  initial begin
    rst            = 1'b1;
    valid          = 1'b0;
    enter_edge     = 1'b0;
    num_or_operand = 8'd0;
    step();
    step();
    check("reset state", 32'(state_dbg), 0);
    check("reset result", 32'(result), 0);
    check("reset neg", 32'(result_neg), 0);
    check("reset result_valid", 32'(result_valid), 0);
    check("reset busy", 32'(busy), 0);
    check("reset op_ctrl", 32'(op_ctrl), 0);
    rst = 1'b0;
    step();

    // Arithmetic
    run_calc("add 25+17",   8'd25,  4'hA, 8'd17,  42,    1'b0, 1, 1'b0);
    run_calc("sub 10-30",   8'd10,  4'hB, 8'd30,  20,    1'b1, 1, 1'b0);
    run_calc("sub 30-30",   8'd30,  4'hB, 8'd30,  0,     1'b0, 1, 1'b0);
    run_calc("sub 200-55",  8'd200, 4'hB, 8'd55,  145,   1'b0, 1, 1'b0);
    run_calc("add 255+255", 8'd255, 4'hA, 8'd255, 510,   1'b0, 1, 1'b0);
    run_calc("mul 255*255", 8'd255, 4'hC, 8'd255, 65025, 1'b0, 8, 1'b1);
    run_calc("mul 0*200",   8'd0,   4'hC, 8'd200, 0,     1'b0, 8, 1'b0);
    run_calc("mul 13*11",   8'd13,  4'hC, 8'd11,  143,   1'b0, 8, 1'b0);

    // Guards: Enter without a number, unknown operator, clear
    enter();
    check("enter w/o A ignored", 32'(state_dbg), 0);
    send(8'd7);
    enter();
    check("to S_OP", 32'(state_dbg), 1);
    send(8'h0F);
    check("code F ignored", 32'(state_dbg), 1);
    check("code F op_ctrl", 32'(op_ctrl), 1);
    enter();
    check("enter in S_OP ignored", 32'(state_dbg), 1);
    send(8'h0D);
    check("clear to S_A", 32'(state_dbg), 0);
    enter();
    check("a_seen cleared by D", 32'(state_dbg), 0);

    // Overwrite and coincident valid+enter in S_A and S_B
    send(8'd5);
    valid = 1'b1; num_or_operand = 8'd9; enter_edge = 1'b1;
    step();
    valid = 1'b0; num_or_operand = 8'd0; enter_edge = 1'b0;
    check("coincide A commit", 32'(state_dbg), 1);
    send(8'h0A);
    enter();
    check("enter w/o B ignored", 32'(state_dbg), 2);
    send(8'd6);
    valid = 1'b1; num_or_operand = 8'd1; enter_edge = 1'b1;
    step();
    valid = 1'b0; num_or_operand = 8'd0; enter_edge = 1'b0;
    check("coincide B busy", 32'(busy), 1);
    step();
    check("coincide result_valid", 32'(result_valid), 1);
    check("coincide result 9+1", 32'(result), 10);
    step();

    // Reset during the 4th multiply cycle
    send(8'd200);
    enter();
    send(8'h0C);
    send(8'd100);
    enter_edge = 1'b1;
    step();
    enter_edge = 1'b0;
    step();
    step();
    step();
    check("mid-mul busy", 32'(busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort state", 32'(state_dbg), 0);
    check("abort result", 32'(result), 0);
    check("abort neg", 32'(result_neg), 0);
    check("abort busy", 32'(busy), 0);
    check("abort op_ctrl", 32'(op_ctrl), 0);
    check("abort result_valid", 32'(result_valid), 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("no late result_valid", 32'(result_valid), 0);
    end

    run_calc("add 1+2 after abort", 8'd1, 4'hA, 8'd2, 3, 1'b0, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
